// File: rtl/pipe_trace_pkg.sv
// -----------------------------------------------------------------------------
// pipe_trace_pkg
// Shared definitions for the pipeline trace buffer.
//
// Contents:
//   trState_t        capture FSM state encoding (TR_IDLE/TR_ARMED/TR_POST/TR_DONE)
//   TS_W             width of the optional cycle timestamp field
//   WB_DEST_W        width of the writeback destination register field
//   entry offset helpers, functions of DATA_W and NUM_STAGES
//
// Entry layout, MSB to LSB:
//   [timestamp], pc, instr stage NUM_STAGES-1 .. 0, wb_en, wb_dest, wb_data
// The timestamp field exists only when PIPE_TRACE_TIMESTAMP_EN is defined.
// -----------------------------------------------------------------------------
package pipe_trace_pkg;

    typedef enum logic [1:0] {
        TR_IDLE  = 2'd0,
        TR_ARMED = 2'd1,
        TR_POST  = 2'd2,
        TR_DONE  = 2'd3
    } trState_t;

    localparam int TS_W      = 16;
    localparam int WB_DEST_W = 5;

    // Writeback data sits at the bottom of the entry.
    function automatic int wbDataLsb();
        return 0;
    endfunction

    function automatic int wbDestLsb(input int dataW);
        return dataW;
    endfunction

    function automatic int wbEnBit(input int dataW);
        return dataW + WB_DEST_W;
    endfunction

    // Stage 0 (IF) is the lowest instruction slot, so the whole instruction
    // bus can be dropped in as one contiguous field.
    function automatic int instrLsb(input int dataW, input int stage);
        return dataW + WB_DEST_W + 1 + stage * dataW;
    endfunction

    function automatic int pcLsb(input int dataW, input int numStages);
        return instrLsb(dataW, numStages);
    endfunction

    function automatic int tsLsb(input int dataW, input int numStages);
        return pcLsb(dataW, numStages) + dataW;
    endfunction

    // Entry width without the timestamp: (NUM_STAGES+2)*DATA_W + 6.
    function automatic int entryBaseWidth(input int dataW, input int numStages);
        return tsLsb(dataW, numStages);
    endfunction

endpackage

// File: rtl/pipe_trace_buffer_trace_ram.sv
// -----------------------------------------------------------------------------
// trace_ram
// Simple dual-port storage for trace entries: DEPTH words of ENTRY_W bits,
// one synchronous write port and one registered read port. Contents are not
// reset; the top module only exposes slots it knows have been written.
//
// Ports:
//   clock    in   write and read clock
//   wrEn     in   write strobe
//   wrAddr   in   write slot
//   wrData   in   entry to store
//   rdEn     in   read strobe; rdData updates on the next edge
//   rdAddr   in   read slot
//   rdData   out  registered read data
// -----------------------------------------------------------------------------
module trace_ram
    import pipe_trace_pkg::*;
#(
    parameter  int ENTRY_W = 230,
    parameter  int DEPTH   = 16,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic               clock,
    input  logic               wrEn,
    input  logic [AW-1:0]      wrAddr,
    input  logic [ENTRY_W-1:0] wrData,
    input  logic               rdEn,
    input  logic [AW-1:0]      rdAddr,
    output logic [ENTRY_W-1:0] rdData
);

    logic [ENTRY_W-1:0] mem [DEPTH];

    // Write port: one entry per enabled cycle, no reset on the array.
    always_ff @(posedge clock) begin
        if (wrEn) begin
            mem[wrAddr] <= wrData;
        end
    end

    // Read port: registered so the array can map onto block RAM.
    always_ff @(posedge clock) begin
        if (rdEn) begin
            rdData <= mem[rdAddr];
        end
    end

endmodule

// File: rtl/pipe_trace_buffer.sv
// -----------------------------------------------------------------------------
// pipe_trace_buffer
// On-chip trace capture for the 5-stage pipelined core. Every cycle while
// capturing, one entry {pc, stage instructions, writeback enable/dest/data}
// is written into a circular buffer. A fetch-PC match marks the trigger entry;
// after a programmable number of further entries the buffer freezes and can
// be read back by logical index (0 = oldest valid entry).
//
// Build option:
//   PIPE_TRACE_TIMESTAMP_EN  adds a free-running 16-bit cycle counter stored
//                            as the top field of every entry.
//
// Ports:
//   Clk         in   clock
//   Rst_n       in   asynchronous active-low reset
//   arm_i       in   one-cycle pulse: clear buffer and start capture
//   trig_pc_i   in   trigger PC value
//   post_cnt_i  in   entries to record after the trigger (sampled on arm)
//   pc_i        in   current fetch PC
//   instr_i     in   stage instructions, stage k at [k*DATA_W +: DATA_W]
//   wb_en_i     in   writeback enable
//   wb_dest_i   in   writeback register
//   wb_data_i   in   writeback data
//   rd_en_i     in   read request (honoured in DONE)
//   rd_idx_i    in   logical read index
//   rd_data_o   out  entry read, one cycle after the request
//   rd_valid_o  out  rd_data_o valid
//   state_o     out  0 IDLE, 1 ARMED, 2 POST, 3 DONE
//   fill_o      out  valid entry count, saturating at DEPTH
//   trig_idx_o  out  logical index of the trigger entry (meaningful in DONE)
// -----------------------------------------------------------------------------
module pipe_trace_buffer
    import pipe_trace_pkg::*;
#(
    parameter  int DATA_W     = 32,
    parameter  int DEPTH      = 16,
    parameter  int NUM_STAGES = 5,
    localparam int AW         = $clog2(DEPTH),
`ifdef PIPE_TRACE_TIMESTAMP_EN
    localparam int ENTRY_W    = entryBaseWidth(DATA_W, NUM_STAGES) + TS_W
`else
    localparam int ENTRY_W    = entryBaseWidth(DATA_W, NUM_STAGES)
`endif
) (
    input  logic                         Clk,
    input  logic                         Rst_n,
    input  logic                         arm_i,
    input  logic [DATA_W-1:0]            trig_pc_i,
    input  logic [AW-1:0]                post_cnt_i,
    input  logic [DATA_W-1:0]            pc_i,
    input  logic [NUM_STAGES*DATA_W-1:0] instr_i,
    input  logic                         wb_en_i,
    input  logic [4:0]                   wb_dest_i,
    input  logic [DATA_W-1:0]            wb_data_i,
    input  logic                         rd_en_i,
    input  logic [AW-1:0]                rd_idx_i,
    output logic [ENTRY_W-1:0]           rd_data_o,
    output logic                         rd_valid_o,
    output logic [1:0]                   state_o,
    output logic [AW:0]                  fill_o,
    output logic [AW-1:0]                trig_idx_o
);

    localparam int WB_DATA_LSB = wbDataLsb();
    localparam int WB_DEST_LSB = wbDestLsb(DATA_W);
    localparam int WB_EN_BIT   = wbEnBit(DATA_W);
    localparam int INSTR_LSB   = instrLsb(DATA_W, 0);
    localparam int PC_LSB      = pcLsb(DATA_W, NUM_STAGES);
    localparam logic [AW:0]   FILL_FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] POST_LAST = AW'(1);

    trState_t           state;
    logic [AW-1:0]      wrPtr;
    logic [AW:0]        fillCnt;
    logic [AW-1:0]      postCnt;
    logic [AW-1:0]      trigSlot;
    logic               rdValidQ;
    logic               rdInRangeQ;

    logic               wrEn;
    logic               rdReq;
    logic [AW-1:0]      oldest;
    logic [AW-1:0]      rdAddr;
    logic               rdInRange;
    logic [ENTRY_W-1:0] wrEntry;
    logic [ENTRY_W-1:0] ramRdData;

    // Capture runs in ARMED and POST; an arm pulse wins over everything and
    // suppresses that cycle's write so a restart always begins empty.
    assign wrEn  = !arm_i && ((state == TR_ARMED) || (state == TR_POST));
    assign rdReq = rd_en_i && (state == TR_DONE) && !arm_i;

    // Once the buffer has wrapped, the next slot to be written holds the
    // oldest surviving entry; before that the history starts at slot 0.
    assign oldest    = (fillCnt == FILL_FULL) ? wrPtr : '0;
    assign rdAddr    = oldest + rd_idx_i;
    assign rdInRange = ({1'b0, rd_idx_i} < fillCnt);

`ifdef PIPE_TRACE_TIMESTAMP_EN
    localparam int TS_LSB = tsLsb(DATA_W, NUM_STAGES);

    logic [TS_W-1:0] tsCnt;

    // Free-running cycle counter; runs in every state and simply wraps.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            tsCnt <= '0;
        end else begin
            tsCnt <= tsCnt + 1'b1;
        end
    end
`endif

    // Assemble one trace entry from the live pipeline taps. The instruction
    // bus already has stage NUM_STAGES-1 at its top, matching the entry
    // layout, so it is copied as a single field.
    always_comb begin
        wrEntry = '0;
        wrEntry[WB_DATA_LSB +: DATA_W]            = wb_data_i;
        wrEntry[WB_DEST_LSB +: WB_DEST_W]         = wb_dest_i;
        wrEntry[WB_EN_BIT]                        = wb_en_i;
        wrEntry[INSTR_LSB +: NUM_STAGES * DATA_W] = instr_i;
        wrEntry[PC_LSB +: DATA_W]                 = pc_i;
`ifdef PIPE_TRACE_TIMESTAMP_EN
        wrEntry[TS_LSB +: TS_W]                   = tsCnt;
`endif
    end

    trace_ram #(
        .ENTRY_W (ENTRY_W),
        .DEPTH   (DEPTH)
    ) u_trace_ram (
        .clock  (Clk),
        .wrEn   (wrEn),
        .wrAddr (wrPtr),
        .wrData (wrEntry),
        .rdEn   (rdReq),
        .rdAddr (rdAddr),
        .rdData (ramRdData)
    );

    // Capture FSM with write pointer, fill count and post-trigger counter.
    // The post counter holds the latched count while ARMED and counts down
    // in POST; the write that takes it from 1 to 0 is the last one. Trigger
    // matches are only looked at in ARMED, so later matches are ignored.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state    <= TR_IDLE;
            wrPtr    <= '0;
            fillCnt  <= '0;
            postCnt  <= '0;
            trigSlot <= '0;
        end else if (arm_i) begin
            state    <= TR_ARMED;
            wrPtr    <= '0;
            fillCnt  <= '0;
            postCnt  <= post_cnt_i;
        end else begin
            case (state)
                TR_ARMED: begin
                    wrPtr <= wrPtr + 1'b1;
                    if (fillCnt != FILL_FULL) begin
                        fillCnt <= fillCnt + 1'b1;
                    end
                    if (pc_i == trig_pc_i) begin
                        trigSlot <= wrPtr;
                        if (postCnt == '0) begin
                            state <= TR_DONE;
                        end else begin
                            state <= TR_POST;
                        end
                    end
                end
                TR_POST: begin
                    wrPtr   <= wrPtr + 1'b1;
                    postCnt <= postCnt - 1'b1;
                    if (fillCnt != FILL_FULL) begin
                        fillCnt <= fillCnt + 1'b1;
                    end
                    if (postCnt == POST_LAST) begin
                        state <= TR_DONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Read-side qualifiers, aligned with the RAM's registered output. An
    // out-of-range index still answers, but with an all-zero entry.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rdValidQ   <= 1'b0;
            rdInRangeQ <= 1'b0;
        end else begin
            rdValidQ   <= rdReq;
            rdInRangeQ <= rdInRange;
        end
    end

    assign rd_valid_o = rdValidQ;
    assign rd_data_o  = (rdValidQ && rdInRangeQ) ? ramRdData : '0;
    assign state_o    = state;
    assign fill_o     = fillCnt;
    // Slot distance from the oldest entry, modulo DEPTH via pointer wrap.
    assign trig_idx_o = (state == TR_DONE) ? (trigSlot - oldest) : '0;

endmodule

// File: tb/tb_pipe_trace_buffer.sv
// -----------------------------------------------------------------------------
// tb_pipe_trace_buffer
// Self-checking bench for pipe_trace_buffer. A behavioural model keeps the
// captured history as a queue of packed entries and derives state, fill,
// trigger index and read data from it each cycle. Directed scenarios come
// from a table; corner cases are hand-written; the tail is randomized.
// Honours PIPE_TRACE_TIMESTAMP_EN when defined.
// -----------------------------------------------------------------------------
module tb_pipe_trace_buffer;

    localparam int DATA_W     = 32;
    localparam int DEPTH      = 16;
    localparam int NUM_STAGES = 5;
    localparam int AW         = 4;
    localparam int BASE_W     = (NUM_STAGES + 2) * DATA_W + 6;
`ifdef PIPE_TRACE_TIMESTAMP_EN
    localparam int ENTRY_W    = BASE_W + 16;
`else
    localparam int ENTRY_W    = BASE_W;
`endif
    localparam int PC_LSB     = (NUM_STAGES + 1) * DATA_W + 6;
    localparam int TS_LSB     = PC_LSB + DATA_W;

    logic                         Clk;
    logic                         Rst_n;
    logic                         arm;
    logic [DATA_W-1:0]            trigPc;
    logic [AW-1:0]                postCnt;
    logic [DATA_W-1:0]            pcIn;
    logic [NUM_STAGES*DATA_W-1:0] instrIn;
    logic                         wbEn;
    logic [4:0]                   wbDest;
    logic [DATA_W-1:0]            wbData;
    logic                         rdEn;
    logic [AW-1:0]                rdIdx;
    logic [ENTRY_W-1:0]           rdData;
    logic                         rdValid;
    logic [1:0]                   stateOut;
    logic [AW:0]                  fillOut;
    logic [AW-1:0]                trigIdxOut;

    int checks   = 0;
    int failures = 0;

    // Model state: captured history (oldest first), entries written since
    // arm, serial number of the trigger entry, latched post count, cycle count.
    logic [ENTRY_W-1:0] hist[$];
    int                 mState;
    int                 totalW;
    int                 trigSerial;
    int                 mPost;
    logic [15:0]        mTs;
    logic               expRdValid;
    logic [ENTRY_W-1:0] expRdData;

    typedef struct {
        logic [DATA_W-1:0] startPc;
        logic [DATA_W-1:0] trigPcV;
        int                post;
        int                expFill;
        int                expTrigIdx;
        logic [DATA_W-1:0] expOldestPc;
        logic [DATA_W-1:0] expNewestPc;
    } scen_t;

    scen_t scenTab[3];

    pipe_trace_buffer #(
        .DATA_W     (DATA_W),
        .DEPTH      (DEPTH),
        .NUM_STAGES (NUM_STAGES)
    ) dut (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .arm_i      (arm),
        .trig_pc_i  (trigPc),
        .post_cnt_i (postCnt),
        .pc_i       (pcIn),
        .instr_i    (instrIn),
        .wb_en_i    (wbEn),
        .wb_dest_i  (wbDest),
        .wb_data_i  (wbData),
        .rd_en_i    (rdEn),
        .rd_idx_i   (rdIdx),
        .rd_data_o  (rdData),
        .rd_valid_o (rdValid),
        .state_o    (stateOut),
        .fill_o     (fillOut),
        .trig_idx_o (trigIdxOut)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    function automatic logic [ENTRY_W-1:0] packEntry(input logic [15:0] ts);
        logic [ENTRY_W-1:0] e;
        e = '0;
        e[BASE_W-1:0] = {pcIn, instrIn, wbEn, wbDest, wbData};
`ifdef PIPE_TRACE_TIMESTAMP_EN
        e[TS_LSB +: 16] = ts;
`else
        if (ts == 16'hFFFF) e = e;
`endif
        return e;
    endfunction

    task automatic checkVal(input string name, input logic [255:0] actual,
                            input logic [255:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic modelReset();
        hist.delete();
        mState     = 0;
        totalW     = 0;
        trigSerial = 0;
        mPost      = 0;
        mTs        = '0;
        expRdValid = 1'b0;
        expRdData  = '0;
    endtask

    // Randomize the pipeline data taps (not the control inputs).
    task automatic applyStimulus();
        for (int k = 0; k < NUM_STAGES; k++) begin
            instrIn[k*DATA_W +: DATA_W] = $urandom;
        end
        wbEn   = 1'($urandom_range(0, 1));
        wbDest = 5'($urandom_range(0, 31));
        wbData = $urandom;
    endtask

    task automatic checkOutput();
        int oldestSerial;
        checkVal("state", 256'(stateOut), 256'(mState));
        checkVal("fill", 256'(fillOut), 256'(hist.size()));
        checkVal("rd_valid", 256'(rdValid), 256'(expRdValid));
        checkVal("rd_data", 256'(rdData), 256'(expRdData));
        if (mState == 3) begin
            oldestSerial = totalW - hist.size();
            checkVal("trig_idx", 256'(trigIdxOut), 256'(trigSerial - oldestSerial));
        end
    endtask

    // One clock: advance the model with the inputs present at the edge,
    // then compare outputs 1 time unit after the edge.
    task automatic stepCycle();
        logic reqOk;
        int   reqIdx;
        @(posedge Clk);
        reqOk  = (mState == 3) && rdEn && !arm;
        reqIdx = int'(rdIdx);
        expRdValid = reqOk;
        expRdData  = '0;
        if (reqOk && reqIdx < hist.size()) expRdData = hist[reqIdx];
        if (arm) begin
            mState = 1;
            hist.delete();
            totalW = 0;
            mPost  = int'(postCnt);
        end else if (mState == 1 || mState == 2) begin
            hist.push_back(packEntry(mTs));
            totalW++;
            if (hist.size() > DEPTH) void'(hist.pop_front());
            if (mState == 1 && pcIn == trigPc) begin
                trigSerial = totalW - 1;
                mState = (mPost == 0) ? 3 : 2;
            end else if (mState == 2 && (totalW - 1 - trigSerial) == mPost) begin
                mState = 3;
            end
        end
        mTs = mTs + 16'd1;
        #1;
        checkOutput();
    endtask

    task automatic readEntry(input int idx, output logic [ENTRY_W-1:0] data,
                             output logic valid);
        rdEn  = 1'b1;
        rdIdx = AW'(idx);
        stepCycle();
        data  = rdData;
        valid = rdValid;
        rdEn  = 1'b0;
    endtask

    task automatic runScenario(input int s);
        logic               done;
        logic [ENTRY_W-1:0] d;
        logic [ENTRY_W-1:0] d1;
        logic               v;
        arm     = 1'b1;
        postCnt = AW'(scenTab[s].post);
        trigPc  = scenTab[s].trigPcV;
        pcIn    = 32'hFFFF_FFF0;
        stepCycle();
        arm  = 1'b0;
        pcIn = scenTab[s].startPc;
        done = 1'b0;
        for (int c = 0; c < 64 && !done; c++) begin
            applyStimulus();
            stepCycle();
            if (stateOut == 2'd3) done = 1'b1;
            else pcIn = pcIn + 32'd4;
        end
        checks++;
        if (!done) begin
            failures++;
            $display("[TB] FAIL s%0d_done_timeout actual=%0d expected=3", s, stateOut);
        end
        checkVal($sformatf("s%0d_fill", s), 256'(fillOut), 256'(scenTab[s].expFill));
        checkVal($sformatf("s%0d_trig_idx", s), 256'(trigIdxOut), 256'(scenTab[s].expTrigIdx));
        readEntry(0, d, v);
        checkVal($sformatf("s%0d_rd0_valid", s), 256'(v), 256'(1));
        checkVal($sformatf("s%0d_rd0_pc", s), 256'(d[PC_LSB +: DATA_W]),
                 256'(scenTab[s].expOldestPc));
        readEntry(scenTab[s].expFill - 1, d1, v);
        checkVal($sformatf("s%0d_rdlast_pc", s), 256'(d1[PC_LSB +: DATA_W]),
                 256'(scenTab[s].expNewestPc));
`ifdef PIPE_TRACE_TIMESTAMP_EN
        if (scenTab[s].expFill > 1) begin
            readEntry(1, d1, v);
            checkVal($sformatf("s%0d_ts_step", s),
                     256'(16'(d1[TS_LSB +: 16] - d[TS_LSB +: 16])), 256'(1));
        end
`endif
    endtask

    initial begin
        logic [ENTRY_W-1:0] d;
        logic               v;
        logic               isArm;

        scenTab[0] = '{32'h100, 32'h120, 3, 12, 8, 32'h100, 32'h12C};
        scenTab[1] = '{32'h180, 32'h200, 4, 16, 11, 32'h1D4, 32'h210};
        scenTab[2] = '{32'h080, 32'h080, 0, 1, 0, 32'h080, 32'h080};

        Rst_n   = 1'b0;
        arm     = 1'b0;
        trigPc  = '0;
        postCnt = '0;
        pcIn    = '0;
        instrIn = '0;
        wbEn    = 1'b0;
        wbDest  = '0;
        wbData  = '0;
        rdEn    = 1'b0;
        rdIdx   = '0;
        modelReset();

        #12;
        checkVal("reset_state", 256'(stateOut), 256'(0));
        checkVal("reset_fill", 256'(fillOut), 256'(0));
        checkVal("reset_rd_valid", 256'(rdValid), 256'(0));
        checkVal("reset_rd_data", 256'(rdData), 256'(0));
        checkVal("reset_trig_idx", 256'(trigIdxOut), 256'(0));
        @(posedge Clk);
        #3;
        Rst_n = 1'b1;
        modelReset();

        // IDLE must not capture or react to a PC match.
        trigPc = 32'h40;
        pcIn   = 32'h40;
        applyStimulus();
        stepCycle();
        stepCycle();

        for (int s = 0; s < 3; s++) begin
            runScenario(s);
        end

        // Out-of-range read in DONE (fill is 1 here).
        readEntry(5, d, v);
        checkVal("oor_rd_valid", 256'(v), 256'(1));
        checkVal("oor_rd_data", 256'(d), 256'(0));

        // Arm and matching PC in the same cycle: arm wins, nothing written.
        arm     = 1'b1;
        trigPc  = 32'h300;
        pcIn    = 32'h300;
        postCnt = AW'(2);
        stepCycle();
        checkVal("armtrig_state", 256'(stateOut), 256'(1));
        checkVal("armtrig_fill", 256'(fillOut), 256'(0));
        arm  = 1'b0;
        pcIn = 32'h304;
        stepCycle();
        pcIn = 32'h300;
        stepCycle();
        checkVal("post_entered", 256'(stateOut), 256'(2));
        pcIn = 32'h308;
        stepCycle();

        // Asynchronous reset in POST takes effect without a clock edge.
        #1;
        Rst_n = 1'b0;
        #1;
        checkVal("async_rst_state", 256'(stateOut), 256'(0));
        checkVal("async_rst_fill", 256'(fillOut), 256'(0));
        checkVal("async_rst_rd_valid", 256'(rdValid), 256'(0));
        modelReset();
        #1;
        Rst_n = 1'b1;

        // Randomized traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            isArm = (mState == 0) || ($urandom_range(0, 49) == 0);
            arm   = isArm;
            if (isArm) begin
                postCnt = AW'($urandom_range(0, DEPTH - 1));
                trigPc  = 32'($urandom_range(0, 31)) * 32'd4;
            end
            pcIn  = 32'($urandom_range(0, 31)) * 32'd4;
            rdEn  = 1'($urandom_range(0, 1));
            rdIdx = AW'($urandom_range(0, DEPTH - 1));
            applyStimulus();
            stepCycle();
        end
        arm  = 1'b0;
        rdEn = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
